fc_layer_seq: RTL and testbench
===============================

Name: fc_layer_seq

Overview:
- Parametrised, time-multiplexed fully-connected layer with a fused argmax. It is the successor to the fixed 100x10 fc plus softmax pair.
- Computes f_fc[o] = sat(bias[o] + sum_i x[i]*w[o][i]) in signed fixed point, processing PAR multiply-accumulates per cycle.
- Optional ReLU is applied to each output, and the index and value of the maximum output are tracked as results are produced.
- Sits at the tail of the CNN pipeline. Its start_flag is chained from the previous layer's over_flag, and its over_flag drives the network done signal.

Parameters:
- DATA_WIDTH, 16, signed two's-complement word width of x, w, bias and f_fc.
- FRAC_BITS, 8, fractional bits of every operand (Q format); products are rescaled by this amount.
- NUM_IN, 100, number of input activations.
- NUM_OUT, 10, number of output nodes; must be >= 2.
- PAR, 1, MAC lanes per cycle; NUM_IN % PAR must equal 0 (checked by elaboration-time $error).
- RELU, 0, when 1 negative outputs are clamped to 0 before storage and argmax.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start_flag  input  1  level; sampled only in IDLE or DONE.
- i_fc  input  NUM_IN*DATA_WIDTH  activations; element k is at bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
- w_fc  input  NUM_IN*NUM_OUT*DATA_WIDTH  weights; w[o][i] is element index o*NUM_IN+i.
- bias  input  NUM_OUT*DATA_WIDTH  per-output bias in the same Q format.
- f_fc  output  NUM_OUT*DATA_WIDTH  registered results; element o is at index o.
- max_value  output  DATA_WIDTH  largest f_fc element.
- max_index  output  $clog2(NUM_OUT)  index of max_value.
- busy  output  1  high in MAC and FINAL.
- over_flag  output  1  level, high in DONE.

Behaviour:
- Reset:
  - state goes to IDLE.
  - f_fc, max_value, max_index, busy and over_flag all go to 0.
  - Internal counters and the accumulator clear.
  - Reset asserted mid-operation aborts the run immediately; no partial results are retained.
- States are IDLE, MAC, FINAL and DONE.
- IDLE or DONE with start_flag=1:
  - Capture i_fc and bias into internal registers.
  - Clear the output index o, lane counter c and accumulator.
  - over_flag goes 0 and the state goes to MAC.
  - This edge is edge 0.
- w_fc is not captured. It must be held stable from edge 0 until over_flag rises; the bench enforces this.
- MAC, each edge:
  - acc += sum over p=0..PAR-1 of x[c*PAR+p] * w[o][c*PAR+p].
  - Products are full 2*DATA_WIDTH signed.
  - acc width is 2*DATA_WIDTH + $clog2(NUM_IN) + 1, so it never overflows.
  - c increments. On the edge processing c = NUM_IN/PAR - 1, go to FINAL.
- FINAL, one edge:
  - r = (acc >>> FRAC_BITS) + sign-extended bias[o]. The shift is arithmetic, so truncation is toward -inf.
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If RELU=1 and r<0, r=0.
  - Write f_fc[o] = r.
  - Argmax update: if o==0 or r > max_value (strictly greater), set max_value=r and max_index=o. Ties therefore keep the lowest index.
  - If o == NUM_OUT-1: go to DONE and set over_flag=1 on this same edge.
  - Otherwise: o++, c=0, acc=0, and return to MAC.
- Latency:
  - over_flag first reads high after edge NUM_OUT*(NUM_IN/PAR + 1).
  - Defaults give 1010 cycles; PAR=4 gives 260 cycles.
- busy is registered. It rises at edge 0 and falls at the edge over_flag rises.
- start_flag handling:
  - start_flag while busy is ignored and has no effect on results or latency.
  - start_flag held high in DONE restarts a new run on the next edge. over_flag is therefore high for exactly 1 cycle when start is tied high.
- Outputs during a run:
  - f_fc elements not yet rewritten keep their previous-run values.
  - max_value and max_index are valid only while over_flag=1.
- DONE holds all outputs until the next start or reset.

Test Plan:
- Identity run. Defaults (DATA_WIDTH=16, FRAC_BITS=8, NUM_IN=100, NUM_OUT=10, PAR=1); x[i]=0x0100 (1.0); w[o][i]=0x0100 for i==o, else 0; bias[o]=o*0x0010. Required: f_fc[o]=0x0100+o*0x0010, max_index=9, max_value=0x0190, over_flag high exactly 1010 cycles after the start edge.
- Saturation. All x=0x7FFF, all w=0x7FFF, bias=0: every f_fc=0x7FFF. Then w=0x8000: every f_fc=0x8000. With RELU=1 and w=0x8000: every f_fc=0x0000 and max_index=0.
- Tie-break and negative max. f_fc targets {-5,-3,-3,-7,...} in Q8 via bias only (x=0): max_index=1, max_value=0xFD00.
- PAR=4 with random vectors versus a golden model. Required: bit-exact f_fc and argmax, over_flag after 260 cycles, busy high for exactly 260 cycles.
- Control.
  - Pulse start_flag again at cycles 5 and 500 of a run: latency and results unchanged.
  - Hold start_flag high across DONE: over_flag 1-cycle pulse, then a second identical run.
- Mid-run reset. Assert rst at cycle 300 for 2 cycles: all outputs 0 immediately (asynchronous). A fresh start then yields correct results with full latency.

Source files
------------

// File: rtl/fc_layer_seq.sv
// Time-multiplexed fully-connected layer with fused argmax: PAR signed MACs per cycle,
// rescale + bias + saturation (+ optional ReLU) per output node, running maximum tracking.
module fc_layer_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int NUM_IN     = 100,
  parameter int NUM_OUT    = 10,
  parameter int PAR        = 1,
  parameter int RELU       = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_flag,
  input  logic [NUM_IN*DATA_WIDTH-1:0]           i_fc,
  input  logic [NUM_IN*NUM_OUT*DATA_WIDTH-1:0]   w_fc,
  input  logic [NUM_OUT*DATA_WIDTH-1:0]          bias,
  output logic [NUM_OUT*DATA_WIDTH-1:0]          f_fc,
  output logic [DATA_WIDTH-1:0]                  max_value,
  output logic [$clog2(NUM_OUT)-1:0]             max_index,
  output logic                                   busy,
  output logic                                   over_flag
);

  localparam int DW  = DATA_WIDTH;
  localparam int PW  = 2 * DW;
  localparam int AW  = 2 * DW + $clog2(NUM_IN) + 1;
  localparam int NCH = NUM_IN / PAR;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int OW  = $clog2(NUM_OUT);
  localparam int XBW = $clog2(NUM_IN * DW);
  localparam int WBW = $clog2(NUM_IN * NUM_OUT * DW);
  localparam int BBW = $clog2(NUM_OUT * DW);

  localparam logic [CW-1:0] C_LAST = CW'(NCH - 1);
  localparam logic [OW-1:0] O_LAST = OW'(NUM_OUT - 1);
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  if (NUM_IN % PAR != 0) begin : g_par_check
    $error("fc_layer_seq: NUM_IN must be a multiple of PAR");
  end
  if (NUM_OUT < 2) begin : g_out_check
    $error("fc_layer_seq: NUM_OUT must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, next_state;
  logic   load, mac_en, fin_en, last_out;

  logic [NUM_IN*DW-1:0]   x_vec;
  logic [NUM_OUT*DW-1:0]  bias_vec;
  logic signed [AW-1:0]   acc;
  logic [CW-1:0]          c_cnt;
  logic [OW-1:0]          o_idx;

  logic [XBW-1:0]         x_base;
  logic [WBW-1:0]         w_base;
  logic [BBW-1:0]         b_base;
  logic [DW-1:0]          xi, wi;
  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   lane_sum;
  logic signed [AW-1:0]   shifted, r_wide;
  logic signed [DW-1:0]   r_sat, r_fin, bias_cur;
  logic                   new_max;

  // Clamp a wide signed result into the DATA_WIDTH two's-complement range.
  function automatic logic signed [DW-1:0] sat_word(input logic signed [AW-1:0] v);
    if (v > SAT_HI) begin
      sat_word = {1'b0, {(DW-1){1'b1}}};
    end else if (v < SAT_LO) begin
      sat_word = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_word = v[DW-1:0];
    end
  endfunction

  // Next-state and control strobes.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    mac_en     = 1'b0;
    fin_en     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_flag) begin
          next_state = S_MAC;
          load       = 1'b1;
        end else begin
          next_state = state;
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        if (c_cnt == C_LAST) begin
          next_state = S_FINAL;
        end else begin
          next_state = S_MAC;
        end
      end
      S_FINAL: begin
        fin_en = 1'b1;
        if (o_idx == O_LAST) begin
          next_state = S_DONE;
        end else begin
          next_state = S_MAC;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // PAR-lane dot-product slice for the current output node and chunk.
  always_comb begin
    lane_sum = '0;
    x_base   = '0;
    w_base   = '0;
    xi       = '0;
    wi       = '0;
    prod     = '0;
    for (int p = 0; p < PAR; p++) begin
      x_base   = XBW'((int'(c_cnt) * PAR + p) * DW);
      w_base   = WBW'((int'(o_idx) * NUM_IN + int'(c_cnt) * PAR + p) * DW);
      xi       = x_vec[x_base +: DW];
      wi       = w_fc[w_base +: DW];
      prod     = {{DW{xi[DW-1]}}, xi} * {{DW{wi[DW-1]}}, wi};
      lane_sum = lane_sum + AW'(prod);
    end
  end

  // Rescale, add bias, saturate, optional ReLU; arithmetic shift floors toward -inf.
  always_comb begin
    b_base   = BBW'(int'(o_idx) * DW);
    bias_cur = bias_vec[b_base +: DW];
    shifted  = acc >>> FRAC_BITS;
    r_wide   = shifted + AW'(bias_cur);
    r_sat    = sat_word(r_wide);
    if ((RELU != 0) && r_sat[DW-1]) begin
      r_fin = '0;
    end else begin
      r_fin = r_sat;
    end
    new_max  = (o_idx == '0) || (r_fin > $signed(max_value));
    last_out = (o_idx == O_LAST);
  end

  // Operand capture, accumulator, counters, result and argmax registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_vec     <= '0;
      bias_vec  <= '0;
      acc       <= '0;
      c_cnt     <= '0;
      o_idx     <= '0;
      f_fc      <= '0;
      max_value <= '0;
      max_index <= '0;
    end else if (load) begin
      x_vec    <= i_fc;
      bias_vec <= bias;
      acc      <= '0;
      c_cnt    <= '0;
      o_idx    <= '0;
    end else if (mac_en) begin
      acc   <= acc + lane_sum;
      c_cnt <= c_cnt + CW'(1);
    end else if (fin_en) begin
      f_fc[b_base +: DW] <= r_fin;
      if (new_max) begin
        max_value <= r_fin;
        max_index <= o_idx;
      end else begin
        max_value <= max_value;
        max_index <= max_index;
      end
      if (!last_out) begin
        o_idx <= o_idx + OW'(1);
        c_cnt <= '0;
        acc   <= '0;
      end else begin
        o_idx <= o_idx;
        c_cnt <= c_cnt;
        acc   <= acc;
      end
    end else begin
      acc <= acc;
    end
  end

  // busy spans MAC/FINAL; over_flag rises on the final write and drops on restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      over_flag <= 1'b0;
    end else if (load) begin
      busy      <= 1'b1;
      over_flag <= 1'b0;
    end else if (fin_en && last_out) begin
      busy      <= 1'b0;
      over_flag <= 1'b1;
    end else begin
      busy      <= busy;
      over_flag <= over_flag;
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed/randomized bench for fc_layer_seq: three instances (PAR=1, PAR=4, RELU=1)
// checked against an integer-arithmetic reference model of the layer.
module tb_fc_layer_seq;

  localparam int DW = 16;
  localparam int NI = 100;
  localparam int NO = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, start4, startr;
  logic [NI*DW-1:0]    i_fc;
  logic [NI*NO*DW-1:0] w_fc;
  logic [NO*DW-1:0]    bias;

  logic [NO*DW-1:0] f0, f4, fr;
  logic [DW-1:0]    mv0, mv4, mvr;
  logic [3:0]       mi0, mi4, mir;
  logic             b0, b4, br, ov0, ov4, ovr;

  fc_layer_seq u0 (.clk(clk), .rst(rst), .start_flag(start0), .i_fc(i_fc), .w_fc(w_fc),
                   .bias(bias), .f_fc(f0), .max_value(mv0), .max_index(mi0), .busy(b0),
                   .over_flag(ov0));
  fc_layer_seq #(.PAR(4)) u4 (.clk(clk), .rst(rst), .start_flag(start4), .i_fc(i_fc),
                   .w_fc(w_fc), .bias(bias), .f_fc(f4), .max_value(mv4), .max_index(mi4),
                   .busy(b4), .over_flag(ov4));
  fc_layer_seq #(.RELU(1)) ur (.clk(clk), .rst(rst), .start_flag(startr), .i_fc(i_fc),
                   .w_fc(w_fc), .bias(bias), .f_fc(fr), .max_value(mvr), .max_index(mir),
                   .busy(br), .over_flag(ovr));

  int sel;
  logic [NO*DW-1:0] cur_f;
  logic [DW-1:0]    cur_mv;
  logic [3:0]       cur_mi;
  logic             cur_busy, cur_over;

  always_comb begin
    cur_f = f0; cur_mv = mv0; cur_mi = mi0; cur_busy = b0; cur_over = ov0;
    case (sel)
      1: begin cur_f = f4; cur_mv = mv4; cur_mi = mi4; cur_busy = b4; cur_over = ov4; end
      2: begin cur_f = fr; cur_mv = mvr; cur_mi = mir; cur_busy = br; cur_over = ovr; end
      default: ;
    endcase
  end

  logic signed [DW-1:0] xs [NI];
  logic signed [DW-1:0] ws [NI*NO];
  logic signed [DW-1:0] bs [NO];
  logic [DW-1:0] exp_f [NO];
  logic [DW-1:0] exp_mv;
  int            exp_mi;
  int tests, fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NI; i++) i_fc[i*DW +: DW] = xs[i];
    for (int k = 0; k < NI*NO; k++) w_fc[k*DW +: DW] = ws[k];
    for (int o = 0; o < NO; o++) bias[o*DW +: DW] = bs[o];
  endtask

  // Reference: exact integer dot product, floor division by 2^8, bias, clamp, ReLU, first-max.
  task automatic model(input bit relu);
    longint s, q, best;
    best = 0;
    for (int o = 0; o < NO; o++) begin
      s = 0;
      for (int i = 0; i < NI; i++) s += longint'(xs[i]) * longint'(ws[o*NI+i]);
      q = s / 256;
      if (s < 0 && (s % 256) != 0) q = q - 1;
      q = q + longint'(bs[o]);
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      if (relu && q < 0) q = 0;
      exp_f[o] = 16'(q);
      if (o == 0 || q > best) begin
        best = q;
        exp_mi = o;
      end
    end
    exp_mv = 16'(best);
  endtask

  task automatic set_start(input bit v);
    case (sel)
      1: start4 = v;
      2: startr = v;
      default: start0 = v;
    endcase
  endtask

  // Entered at the falling edge just after the start edge (edge 0).
  task automatic wait_and_check(input string tag, input bit pulses, input bit hold,
                                input int exp_lat);
    int lat, bcnt;
    lat = 0;
    bcnt = cur_busy ? 1 : 0;
    if (!hold) set_start(1'b0);
    while (!cur_over && lat < 3000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (cur_busy) bcnt++;
      if (!hold) set_start(pulses && (lat == 5 || lat == 500));
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, bcnt, exp_lat);
    chk({tag, "_over"}, {31'd0, cur_over}, 32'd1);
    for (int o = 0; o < NO; o++)
      chk($sformatf("%s_f%0d", tag, o), {16'd0, cur_f[o*DW +: DW]}, {16'd0, exp_f[o]});
    chk({tag, "_max_value"}, {16'd0, cur_mv}, {16'd0, exp_mv});
    chk({tag, "_max_index"}, {28'd0, cur_mi}, exp_mi);
  endtask

  task automatic run(input string tag, input bit pulses);
    set_start(1'b1);
    @(posedge clk);
    @(negedge clk);
    wait_and_check(tag, pulses, 1'b0, (sel == 1) ? 260 : 1010);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NI; i++) xs[i] = 16'(int'($urandom_range(1023, 0)) - 512);
    for (int k = 0; k < NI*NO; k++) ws[k] = 16'(int'($urandom_range(1023, 0)) - 512);
    for (int o = 0; o < NO; o++) bs[o] = 16'(int'($urandom_range(8191, 0)) - 4096);
    apply();
  endtask

  initial begin
    int tv [4];
    tests = 0; fails = 0; sel = 0;
    rst = 1'b1; start0 = 1'b0; start4 = 1'b0; startr = 1'b0;
    for (int i = 0; i < NI; i++) xs[i] = '0;
    for (int k = 0; k < NI*NO; k++) ws[k] = '0;
    for (int o = 0; o < NO; o++) bs[o] = '0;
    apply();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk($sformatf("reset%0d_f", s), {31'd0, cur_f != '0}, 32'd0);
      chk($sformatf("reset%0d_mv", s), {16'd0, cur_mv}, 32'd0);
      chk($sformatf("reset%0d_mi", s), {28'd0, cur_mi}, 32'd0);
      chk($sformatf("reset%0d_busy", s), {31'd0, cur_busy}, 32'd0);
      chk($sformatf("reset%0d_over", s), {31'd0, cur_over}, 32'd0);
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Identity
    for (int i = 0; i < NI; i++) xs[i] = 16'h0100;
    for (int o = 0; o < NO; o++) begin
      for (int i = 0; i < NI; i++) ws[o*NI+i] = (i == o) ? 16'h0100 : 16'h0000;
      bs[o] = 16'(o * 16);
    end
    apply(); model(1'b0);
    run("identity", 1'b0);
    chk("identity_const_idx", {28'd0, cur_mi}, 32'd9);
    chk("identity_const_val", {16'd0, cur_mv}, 32'h0190);
    chk("identity_const_f3", {16'd0, cur_f[3*DW +: DW]}, 32'h0130);

    // Saturation, both signs, and ReLU clamp
    for (int i = 0; i < NI; i++) xs[i] = 16'h7FFF;
    for (int k = 0; k < NI*NO; k++) ws[k] = 16'h7FFF;
    for (int o = 0; o < NO; o++) bs[o] = '0;
    apply(); model(1'b0);
    run("sat_pos", 1'b0);
    chk("sat_pos_const", {16'd0, cur_f[7*DW +: DW]}, 32'h7FFF);
    for (int k = 0; k < NI*NO; k++) ws[k] = 16'h8000;
    apply(); model(1'b0);
    run("sat_neg", 1'b0);
    chk("sat_neg_const", {16'd0, cur_f[2*DW +: DW]}, 32'h8000);
    sel = 2; model(1'b1);
    run("relu_neg", 1'b0);
    chk("relu_const_f", {16'd0, cur_f[5*DW +: DW]}, 32'h0000);
    chk("relu_const_idx", {28'd0, cur_mi}, 32'd0);

    // Tie-break with negative maximum
    sel = 0;
    tv[0] = -5; tv[1] = -3; tv[2] = -3; tv[3] = -7;
    for (int i = 0; i < NI; i++) xs[i] = '0;
    for (int k = 0; k < NI*NO; k++) ws[k] = 16'($urandom_range(65535, 0));
    for (int o = 0; o < NO; o++) bs[o] = 16'(((o < 4) ? tv[o] : (-8 - o)) * 256);
    apply(); model(1'b0);
    run("tie", 1'b0);
    chk("tie_const_idx", {28'd0, cur_mi}, 32'd1);
    chk("tie_const_val", {16'd0, cur_mv}, 32'hFD00);

    // PAR=4 random
    sel = 1;
    for (int r = 0; r < 2; r++) begin
      randomize_data(); model(1'b0);
      run($sformatf("par4_rand%0d", r), 1'b0);
    end

    // Spurious start pulses during a run
    sel = 0;
    randomize_data(); model(1'b0);
    run("pulses", 1'b1);

    // start held high through DONE: one-cycle over_flag, then an identical run
    randomize_data(); model(1'b0);
    set_start(1'b1);
    @(posedge clk);
    @(negedge clk);
    wait_and_check("hold1", 1'b0, 1'b1, 1010);
    @(posedge clk);
    @(negedge clk);
    chk("hold_over_pulse", {31'd0, cur_over}, 32'd0);
    chk("hold_restart_busy", {31'd0, cur_busy}, 32'd1);
    wait_and_check("hold2", 1'b0, 1'b0, 1010);

    // Mid-run asynchronous reset, then a fresh run
    set_start(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0);
    repeat (300) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int o = 0; o < NO; o++)
      chk($sformatf("midrst_f%0d", o), {16'd0, f0[o*DW +: DW]}, 32'd0);
    chk("midrst_mv", {16'd0, mv0}, 32'd0);
    chk("midrst_mi", {28'd0, mi0}, 32'd0);
    chk("midrst_busy", {31'd0, b0}, 32'd0);
    chk("midrst_over", {31'd0, ov0}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run("after_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
